// File: rtl/tiled_conv_mac_accum.sv
// tiled_conv_mac_accum: bias-seeded product accumulator with round/shift/saturate to a fixed-point pixel.
// Optional TILED_CONV_MAC_RELU_EN clamps negative rounded sums to zero before saturation.
module tiled_conv_mac_accum #(
  parameter int PROD_WIDTH = 28,
  parameter int ACC_WIDTH  = 40,
  parameter int OUT_WIDTH  = 16,
  parameter int FRAC_BITS  = 8,
  parameter int CNT_WIDTH  = 12
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [PROD_WIDTH-1:0] in_prod,
  input  logic                         in_last,
  input  logic signed [OUT_WIDTH-1:0]  in_bias,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic        [OUT_WIDTH-1:0]  out_data,
  output logic        [CNT_WIDTH-1:0]  out_beats,
  output logic                         out_sat
);
  localparam logic signed [ACC_WIDTH-1:0] max_v = ACC_WIDTH'((64'sd1 <<< (OUT_WIDTH-1)) - 64'sd1);
  localparam logic signed [ACC_WIDTH-1:0] min_v = ~max_v;
  localparam logic signed [ACC_WIDTH-1:0] half  = ACC_WIDTH'(64'sd1 <<< (FRAC_BITS-1));
  logic signed [ACC_WIDTH-1:0] acc, acc_next, bias_ext, prod_ext, rnd, r, rc;
  logic        [CNT_WIDTH-1:0] cnt, beats_next;
  logic                        first, take, hi, lo;
  logic        [OUT_WIDTH-1:0] sat_val;
  assign in_ready   = !out_valid || out_ready;
  assign take       = in_valid && in_ready;
  assign bias_ext   = ACC_WIDTH'(in_bias);
  assign prod_ext   = ACC_WIDTH'(in_prod);
  assign acc_next   = (first ? (bias_ext <<< FRAC_BITS) : acc) + prod_ext;
  assign beats_next = first ? CNT_WIDTH'(1) : cnt + CNT_WIDTH'(1);
  assign rnd        = acc_next + half;
  assign r          = rnd >>> FRAC_BITS;
`ifdef TILED_CONV_MAC_RELU_EN
  assign rc = (r < 0) ? '0 : r;
`else
  assign rc = r;
`endif
  assign hi      = rc > max_v;
  assign lo      = rc < min_v;
  assign sat_val = hi ? max_v[OUT_WIDTH-1:0] : lo ? min_v[OUT_WIDTH-1:0] : rc[OUT_WIDTH-1:0];
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
      out_sat   <= 1'b0;
    end else begin
      if (take) begin
        first <= in_last;
        if (in_last) begin
          out_data  <= sat_val;
          out_sat   <= hi || lo;
          out_beats <= beats_next;
        end else begin
          acc <= acc_next;
          cnt <= beats_next;
        end
      end
      // a last beat accepted while draining reloads the register without a bubble
      if (take && in_last) out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_tiled_conv_mac_accum.sv
// tb_tiled_conv_mac_accum: directed table-driven bench with hand-computed results plus corner sequences.
module tb_tiled_conv_mac_accum;
  logic        ap_clk = 1'b0, ap_rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_last = 1'b0;
  logic [27:0] in_prod = '0;
  logic [15:0] in_bias = '0;
  logic        out_valid, out_ready = 1'b1, out_sat;
  logic [15:0] out_data;
  logic [11:0] out_beats;
  int checks = 0, errors = 0;
`ifdef TILED_CONV_MAC_RELU_EN
  localparam bit relu = 1'b1;
`else
  localparam bit relu = 1'b0;
`endif
  typedef struct {
    logic [15:0] bias;
    logic [27:0] prod;
    int          n;
    logic [15:0] d;
    logic [11:0] b;
    logic        s;
  } vec_t;
  vec_t vecs[13];

  tiled_conv_mac_accum dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_prod(in_prod), .in_last(in_last), .in_bias(in_bias),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats), .out_sat(out_sat)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic beat(input logic [27:0] prod, input logic last, input logic [15:0] bias);
    int n = 0;
    in_valid = 1'b1;
    in_prod  = prod;
    in_last  = last;
    in_bias  = bias;
    while (!in_ready && n < 20) begin
      @(posedge ap_clk);
      #1;
      n++;
    end
    if (n == 20) chk("ready_timeout", 32'(in_ready), 32'd1);
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{16'h0100, 28'h0010000, 3, 16'h0400, 12'd3, 1'b0};
    vecs[1]  = '{16'h0000, 28'h0000080, 1, 16'h0001, 12'd1, 1'b0};
    vecs[2]  = '{16'h0000, 28'h000007F, 1, 16'h0000, 12'd1, 1'b0};
    vecs[3]  = '{16'h0000, 28'hFFFFF80, 1, 16'h0000, 12'd1, 1'b0};
    vecs[4]  = '{16'h0000, 28'hFFFFF7F, 1, relu ? 16'h0000 : 16'hFFFF, 12'd1, 1'b0};
    vecs[5]  = '{16'h7FFF, 28'h7FFFFFF, 4, 16'h7FFF, 12'd4, 1'b1};
    vecs[6]  = '{16'h8000, 28'h8000000, 4, relu ? 16'h0000 : 16'h8000, 12'd4, !relu};
    vecs[7]  = '{16'hFFFF, 28'hFFFFF00, 1, relu ? 16'h0000 : 16'hFFFE, 12'd1, 1'b0};
    vecs[8]  = '{16'h7FFF, 28'h0000000, 1, 16'h7FFF, 12'd1, 1'b0};
    vecs[9]  = '{16'h7FFF, 28'h0000080, 1, 16'h7FFF, 12'd1, 1'b1};
    vecs[10] = '{16'h8000, 28'hFFFFF80, 1, relu ? 16'h0000 : 16'h8000, 12'd1, 1'b0};
    vecs[11] = '{16'h8000, 28'hFFFFF7F, 1, relu ? 16'h0000 : 16'h8000, 12'd1, !relu};
    vecs[12] = '{16'h0010, 28'h0000100, 2, 16'h0012, 12'd2, 1'b0};
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_beats", 32'(out_beats), 0);
    chk("rst_sat", 32'(out_sat), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    foreach (vecs[i]) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        beat(vecs[i].prod, k == vecs[i].n - 1, k == 0 ? vecs[i].bias : 16'hDEAD);
        if (k == vecs[i].n - 2) chk($sformatf("v%0d_early_valid", i), 32'(out_valid), 0);
      end
      chk($sformatf("v%0d_valid", i), 32'(out_valid), 1);
      chk($sformatf("v%0d_data", i), 32'(out_data), 32'(vecs[i].d));
      chk($sformatf("v%0d_beats", i), 32'(out_beats), 32'(vecs[i].b));
      chk($sformatf("v%0d_sat", i), 32'(out_sat), 32'(vecs[i].s));
    end
    @(posedge ap_clk);
    #1;
    chk("drain_valid", 32'(out_valid), 0);
    // backpressure: hold a result while the next window waits
    out_ready = 1'b0;
    beat(28'h0, 1'b1, 16'h0020);
    chk("bp_first", 32'(out_data), 32'h0020);
    in_valid = 1'b1;
    in_prod  = 28'h0;
    in_last  = 1'b1;
    in_bias  = 16'h0030;
    for (int c = 0; c < 5; c++) begin
      @(posedge ap_clk);
      #1;
      chk($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 0);
      chk($sformatf("bp_valid_%0d", c), 32'(out_valid), 1);
      chk($sformatf("bp_data_%0d", c), 32'(out_data), 32'h0020);
    end
    @(negedge ap_clk);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(in_ready), 1);
    @(posedge ap_clk);
    #1;
    in_valid = 1'b0;
    chk("bp_reload_valid", 32'(out_valid), 1);
    chk("bp_reload_data", 32'(out_data), 32'h0030);
    @(posedge ap_clk);
    #1;
    chk("bp_drained", 32'(out_valid), 0);
    // back-to-back single-beat windows, bias re-sampled each time
    for (int w = 1; w <= 4; w++) begin
      beat(28'h0, 1'b1, 16'(w));
      chk($sformatf("b2b_data_%0d", w), 32'(out_data), 32'(w));
      chk($sformatf("b2b_beats_%0d", w), 32'(out_beats), 1);
      chk($sformatf("b2b_valid_%0d", w), 32'(out_valid), 1);
    end
    // beat counter wraps modulo 4096
    for (int k = 0; k < 4097; k++) beat(28'h0, k == 4096, k == 0 ? 16'h0005 : 16'h1234);
    chk("wrap_beats", 32'(out_beats), 1);
    chk("wrap_data", 32'(out_data), 32'h0005);
    // reset mid-window
    beat(28'h0010000, 1'b0, 16'h0100);
    beat(28'h0010000, 1'b0, 16'h0100);
    ap_rst_n = 1'b0;
    #2;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_beats", 32'(out_beats), 0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    beat(28'h0, 1'b1, 16'h0010);
    chk("post_rst_data", 32'(out_data), 32'h0010);
    chk("post_rst_beats", 32'(out_beats), 1);
    chk("post_rst_valid", 32'(out_valid), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/tiled_conv_mac_accum.md
Name: tiled_conv_mac_accum

Overview:
Downstream consumer of the 16s x 16s -> 28s product multiplier in the tiled convolution datapath. It accumulates a stream of signed 28-bit products over one kernel window, seeded with a per-window bias. It then rounds, shifts and saturates the sum to a 16-bit fixed-point output pixel. Input and output use valid/ready handshakes, with a one-entry output register.

Parameters:
PROD_WIDTH, 28, signed product width from the multiplier
ACC_WIDTH, 40, signed accumulator width; must be >= PROD_WIDTH + 12
OUT_WIDTH, 16, signed output pixel width; also the bias width
FRAC_BITS, 8, fractional bits of the bias and output. Products carry 2*FRAC_BITS fractional bits.
CNT_WIDTH, 12, width of the beat counter

Ports:
ap_clk  in  1  clock; all state updates on the rising edge
ap_rst_n  in  1  asynchronous active-low reset
in_valid  in  1  product beat valid
in_ready  out  1  product beat accepted when in_valid && in_ready
in_prod  in  PROD_WIDTH  signed product (din0*din1 of the multiplier)
in_last  in  1  marks the final beat of the window
in_bias  in  OUT_WIDTH  signed bias; sampled only on the first beat of a window
out_valid  out  1  result held valid
out_ready  in  1  downstream accepts the result when out_valid && out_ready
out_data  out  OUT_WIDTH  signed saturated result
out_beats  out  CNT_WIDTH  number of beats in the emitted window
out_sat  out  1  result was clipped during saturation

Behaviour:
- Reset, asynchronous and active-low, clears all state: out_valid=0, out_data=0, out_beats=0, out_sat=0, acc=0, beat counter=0, first=1.
- in_ready = !out_valid || out_ready. This is combinational, with no bubble when the output drains in the same cycle.
- acc_next on an accepted beat:
  - if first=1: sign-extend(in_bias) << FRAC_BITS, plus sign-extend(in_prod)
  - otherwise: acc + sign-extend(in_prod)
  - all arithmetic is ACC_WIDTH two's complement and wraps silently.
- States:
  - IDLE (first=1, acc don't-care)
  - ACCUM (first=0)
- Accepted beat with in_last=0:
  - acc <= acc_next
  - cnt <= (first ? 1 : cnt+1)
  - first <= 0
- Accepted beat with in_last=1:
  - compute r = (acc_next + 2^(FRAC_BITS-1)) >>> FRAC_BITS, an arithmetic shift with round-half-up.
  - clip r to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]
  - register the clipped value into out_data and set out_sat if clipping occurred
  - out_beats <= (first ? 1 : cnt+1)
  - out_valid <= 1, first <= 1
  - latency is 1 cycle from the last-beat handshake to out_valid.
- A single-beat window (first=1, in_last=1) is legal: result = bias + product.
- out_valid falls when out_ready=1 and no new last beat is accepted in the same cycle.
- A simultaneous output drain and last-beat accept loads the new result, and out_valid stays 1.
- While out_valid=1 and out_ready=0, in_ready=0 and all state holds. out_data, out_beats and out_sat are stable until the handshake completes.
- The beat counter wraps modulo 2^CNT_WIDTH; no error is flagged.
- in_bias on non-first beats is ignored.
- in_prod, in_last and in_bias are don't-care when in_valid=0.

Optional Feature:
TILED_CONV_MAC_RELU_EN
- Defined: after rounding and before saturation, negative r is forced to 0. out_sat is set only for positive overflow.
- Undefined: signed output, with saturation at both bounds.

Test Plan:
1. Basic window, FRAC_BITS=8:
   - stimulus: bias 0x0100; three beats of in_prod=65536, last on beat 3, out_ready=1
   - response: out_data=0x0400, out_beats=3, out_sat=0, out_valid one cycle after the last handshake.
2. Rounding, single-beat windows with bias 0:
   - prod=128 -> out_data=1
   - prod=127 -> 0
   - prod=-128 -> 0
   - prod=-129 -> -1 (0xFFFF)
3. Saturation, bias 0x7FFF:
   - stimulus: four beats of 0x7FFFFFF
   - response: out_data=0x7FFF, out_sat=1
   - a matching negative window (bias 0x8000, beats 0x8000000) -> 0x8000, out_sat=1. With RELU_EN the negative window gives 0x0000.
4. Backpressure:
   - stimulus: out_ready=0 after a result; next window's beats presented
   - response: in_ready=0, outputs stable for 5 cycles; on out_ready=1 the result drains and in_ready returns in the same cycle.
5. Back-to-back windows:
   - stimulus: single-beat windows every cycle with out_ready=1
   - response: one result per cycle, bias re-sampled per window, out_beats=1 each.
6. Reset mid-window:
   - stimulus: ap_rst_n low after 2 of 4 beats, then a fresh window with bias 0x0010 and prod 0
   - response: out_data=0x0010, out_beats=1; no residue from the aborted window.
